spi_flash_target: RTL and testbench
===================================

SPI_FLASH_TARGET -- requirements
Module: spi_flash_target

Interface
REQ-001 Parameter MEM_DEPTH, default 4096, meaning byte capacity of the internal array; power of two, 256..65536.
REQ-002 Parameter JEDEC_ID, default 24'hEF4016, meaning the 3-byte value returned by command 0x9F, MSB byte first.
REQ-003 clk  input  1  single system clock; every register is clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_flash_sclk  input  1  SPI serial clock from the master, asynchronous to clk.
REQ-006 i_flash_cs_n  input  1  SPI chip select from the master, active low, asynchronous to clk.
REQ-007 i_flash_mosi  input  1  master-out/slave-in data line.
REQ-008 o_flash_miso  output  1  master-in/slave-out data line.
REQ-009 load_we  input  1  preload write strobe, one byte per clk cycle.
REQ-010 load_addr  input  $clog2(MEM_DEPTH)  preload byte address.
REQ-011 load_data  input  8  preload byte value.
REQ-012 o_active  output  1  high while a transaction is in progress (synchronized cs_n low).
REQ-013 o_bad_cmd  output  1  one-cycle pulse when an unsupported opcode completes.

Function
REQ-014 The block shall pass sclk, cs_n and mosi through 2-flop synchronizers and detect sclk edges from the synchronized value; the master shall keep each sclk half-period at 4 or more clk cycles.
REQ-015 The block shall operate in SPI mode 0: it samples mosi on a synchronized sclk rising edge and updates miso exactly 1 clk after a synchronized falling edge is detected.
REQ-016 Bit order on both mosi and miso shall be MSB first; the 3-bit bit counter shall wrap 7 to 0 at each byte boundary.
REQ-017 The FSM shall have the states IDLE, CMD, ADDR, DUMMY, DATA, ID and IGNORE.
REQ-018 Synchronized cs_n falling shall move IDLE to CMD.
REQ-019 After 8 bits in CMD: opcode 0x03 shall go to ADDR, opcode 0x9F shall go to ID, and any other opcode shall go to IGNORE and pulse o_bad_cmd.
REQ-020 ADDR shall shift in 24 bits; the address register shall keep the low $clog2(MEM_DEPTH) bits, and the upper bits shall be ignored.
REQ-021 On the falling edge after the 24th address bit, the block shall present bit 7 of mem[addr] on miso and shall enter DATA.
REQ-022 DATA shall stream consecutive bytes; the address shall increment after each byte and wrap from MEM_DEPTH-1 to 0.
REQ-023 ID shall return JEDEC_ID[23:16], [15:8] and [7:0], then 0xFF for every later byte.
REQ-024 In IGNORE, the block shall hold miso at 0 until cs_n is deasserted.
REQ-025 Synchronized cs_n high shall return the FSM to IDLE from any state within 1 clk, discard any partial byte, and drive miso to 0.
REQ-026 Preload writes shall have priority over nothing else; a load_we in the same cycle as a DATA fetch of the same address shall return the old byte.
REQ-027 miso shall be 0 whenever the FSM is not in DATA or ID.

Reset
REQ-028 Reset shall force: state IDLE, o_flash_miso 0, o_active 0, o_bad_cmd 0, bit counter 0, address 0, and synchronizer flops to their idle values (sclk 0, cs_n 1, mosi 0).
REQ-029 Reset shall not clear the memory contents.
REQ-030 When reset is asserted mid-transaction, the block shall ignore the remainder of that transaction until cs_n is deasserted and asserted again.

Configuration
REQ-031 With SPI_TARGET_FAST_READ_EN defined, opcode 0x0B shall be accepted and shall behave as ADDR then DUMMY (8 sclk cycles, miso 0) then DATA.
REQ-032 Without SPI_TARGET_FAST_READ_EN, opcode 0x0B shall be treated as unsupported: o_bad_cmd pulses and the FSM enters IGNORE.

Verification
REQ-033 Scenario 1: preload mem[0x010..0x013] = 11,22,33,44; send 03 000010 and clock 32 data bits -> miso bytes 0x11,0x22,0x33,0x44.
REQ-034 Scenario 2: MEM_DEPTH = 4096, mem[0xFFF] = 0xA5, mem[0x000] = 0x5A; send 03 00FFFF and read 2 bytes -> 0xA5, 0x5A (address wrap).
REQ-035 Scenario 3: send 9F and read 4 bytes -> 0xEF, 0x40, 0x16, 0xFF.
REQ-036 Scenario 4: send opcode 0x55 -> o_bad_cmd high for exactly 1 clk and miso 0 for the rest of the transaction.
REQ-037 Scenario 5: deassert cs_n after 13 address bits, then send 03 000010 -> first byte is 0x11 (no residue from the aborted transaction).
REQ-038 Scenario 6: with the macro defined, send 0B 000011 plus 8 dummy clocks -> 0x22; with the macro undefined, the same sequence -> o_bad_cmd pulse and miso 0.

Source files
------------

// File: rtl/spi_flash_target.sv
// SPI mode-0 read-only flash target: 0x03 read, 0x9F JEDEC ID, preloadable byte array.
// Define SPI_TARGET_FAST_READ_EN to also accept 0x0B fast read (address, 8 dummy clocks, data).
module spi_flash_target #(
    parameter int          MEM_DEPTH = 4096,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_flash_sclk,
    input  logic                         i_flash_cs_n,
    input  logic                         i_flash_mosi,
    output logic                         o_flash_miso,
    input  logic                         load_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
    input  logic [7:0]                   load_data,
    output logic                         o_active,
    output logic                         o_bad_cmd
);

    localparam int AW = $clog2(MEM_DEPTH);

`ifdef SPI_TARGET_FAST_READ_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, ID, IGNORE} state_t;

    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'hFF;
        endcase
    endfunction

    logic [7:0]    mem [MEM_DEPTH];
    state_t        state, state_nx;
    logic          sclk_p0, sclk_p1, sclk_p2;
    logic          cs_p0, cs_p1;
    logic          mosi_p0, mosi_p1;
    logic          vld_p0, vld_p1;
    logic          armed;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [1:0]    id_idx;
    logic [AW-1:0] addr;
    logic          fast;
    logic [6:0]    cmd_sr;
    logic [6:0]    tx_sr;
    logic          rise, fall, fast_op, bad_nx;
    logic [7:0]    opcode_in, fetch_byte;

    always_comb begin
        rise       = sclk_p1 & ~sclk_p2;
        fall       = ~sclk_p1 & sclk_p2;
        opcode_in  = {cmd_sr, mosi_p1};
        fast_op    = FAST_EN && (opcode_in == 8'h0B);
        fetch_byte = (state == DATA) ? mem[addr] : id_byte(id_idx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        bad_nx   = 1'b0;
        if (cs_p1) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (armed) state_nx = CMD;
                CMD: if (rise && bit_cnt == 3'd7) begin
                    if (opcode_in == 8'h03)      state_nx = ADDR;
                    else if (opcode_in == 8'h9F) state_nx = ID;
                    else if (fast_op)            state_nx = ADDR;
                    else begin
                        state_nx = IGNORE;
                        bad_nx   = 1'b1;
                    end
                end
                ADDR: if (rise && bit_cnt == 3'd7 && byte_cnt == 2'd2)
                    state_nx = fast ? DUMMY : DATA;
                DUMMY: if (rise && bit_cnt == 3'd7) state_nx = DATA;
                default: state_nx = state;
            endcase
        end
    end

    // Stage boundary: 2-flop synchronizers, edge history and transaction control
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_p0 <= 1'b0; sclk_p1 <= 1'b0; sclk_p2 <= 1'b0;
            cs_p0   <= 1'b1; cs_p1   <= 1'b1;
            mosi_p0 <= 1'b0; mosi_p1 <= 1'b0;
            vld_p0  <= 1'b0; vld_p1  <= 1'b0;
            armed   <= 1'b0;
            bit_cnt <= 3'd0; byte_cnt <= 2'd0; id_idx <= 2'd0;
            addr    <= '0;
            fast    <= 1'b0;
            o_flash_miso <= 1'b0;
            o_bad_cmd    <= 1'b0;
        end else begin
            sclk_p0 <= i_flash_sclk; sclk_p1 <= sclk_p0; sclk_p2 <= sclk_p1;
            cs_p0   <= i_flash_cs_n; cs_p1   <= cs_p0;
            mosi_p0 <= i_flash_mosi; mosi_p1 <= mosi_p0;
            vld_p0  <= 1'b1; vld_p1 <= vld_p0;
            // Only a cs_n high seen after the synchronizers refill may start a transaction
            armed     <= armed | (vld_p1 & cs_p1);
            o_bad_cmd <= bad_nx;
            if (cs_p1 || state == IDLE) begin
                bit_cnt      <= 3'd0;
                byte_cnt     <= 2'd0;
                id_idx       <= 2'd0;
                o_flash_miso <= 1'b0;
            end else begin
                if (rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (state == CMD && bit_cnt == 3'd7) fast <= fast_op;
                    if (state == ADDR) begin
                        addr <= {addr[AW-2:0], mosi_p1};
                        if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                if (state == DATA || state == ID) begin
                    if (fall) begin
                        if (bit_cnt == 3'd0) begin
                            o_flash_miso <= fetch_byte[7];
                            if (state == DATA)       addr   <= addr + {{(AW-1){1'b0}}, 1'b1};
                            else if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                        end else begin
                            o_flash_miso <= tx_sr[6];
                        end
                    end
                end else begin
                    o_flash_miso <= 1'b0;
                end
            end
        end
    end

    // Stage boundary: data shift registers and byte array (not reset)
    always_ff @(posedge clk) begin
        if (rise) cmd_sr <= {cmd_sr[5:0], mosi_p1};
        if (fall && (state == DATA || state == ID))
            tx_sr <= (bit_cnt == 3'd0) ? fetch_byte[6:0] : {tx_sr[5:0], 1'b0};
        if (load_we) mem[load_addr] <= load_data;
    end

    assign o_active = (state != IDLE);

endmodule

// File: tb/tb_spi_flash_target.sv
// Directed bench for spi_flash_target: read, address wrap, JEDEC ID, bad opcode, abort, fast read, reset mid-transaction.
module tb_spi_flash_target;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk, cs_n, mosi;
    logic        miso;
    logic        load_we;
    logic [11:0] load_addr;
    logic [7:0]  load_data;
    logic        active, bad_cmd;

    int checks = 0;
    int errors = 0;
    int bad_cycles = 0;

    always #5 clk = ~clk;

    spi_flash_target #(.MEM_DEPTH(4096), .JEDEC_ID(24'hEF4016)) dut (
        .clk(clk), .reset(reset),
        .i_flash_sclk(sclk), .i_flash_cs_n(cs_n), .i_flash_mosi(mosi),
        .o_flash_miso(miso),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .o_active(active), .o_bad_cmd(bad_cmd)
    );

    always @(negedge clk) if (bad_cmd === 1'b1) bad_cycles++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sbit(input logic b, output logic r);
        mosi = b;
        wait_clk(6);
        sclk = 1'b1;
        r = miso;
        wait_clk(6);
        sclk = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] t, output logic [7:0] r);
        logic rb;
        for (int i = 7; i >= 0; i--) begin
            sbit(t[i], rb);
            r[i] = rb;
        end
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_end();
        wait_clk(6);
        cs_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic load(input logic [11:0] a, input logic [7:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        wait_clk(1);
        load_we = 1'b0;
    endtask

    task automatic read_cmd(input logic [7:0] op, input logic [23:0] a);
        logic [7:0] r;
        xfer(op, r);
        xfer(a[23:16], r);
        xfer(a[15:8], r);
        xfer(a[7:0], r);
    endtask

    initial begin
        logic [7:0] r;
        logic       rb;
        int         b0;
        reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        load_we = 1'b0; load_addr = '0; load_data = '0;
        wait_clk(3);
        check("reset_miso", {31'd0, miso}, 32'd0);
        check("reset_active", {31'd0, active}, 32'd0);
        check("reset_bad_cmd", {31'd0, bad_cmd}, 32'd0);
        reset = 1'b0;
        wait_clk(4);

        load(12'h010, 8'h11); load(12'h011, 8'h22);
        load(12'h012, 8'h33); load(12'h013, 8'h44);
        load(12'hFFF, 8'hA5); load(12'h000, 8'h5A);

        // Plain read of four bytes
        cs_begin();
        check("active_in_txn", {31'd0, active}, 32'd1);
        read_cmd(8'h03, 24'h000010);
        xfer(8'h00, r); check("s1_byte0", {24'd0, r}, 32'h11);
        xfer(8'h00, r); check("s1_byte1", {24'd0, r}, 32'h22);
        xfer(8'h00, r); check("s1_byte2", {24'd0, r}, 32'h33);
        xfer(8'h00, r); check("s1_byte3", {24'd0, r}, 32'h44);
        cs_end();
        check("active_after_cs", {31'd0, active}, 32'd0);

        // Upper address bits ignored, wrap at top of array
        cs_begin();
        read_cmd(8'h03, 24'h00FFFF);
        xfer(8'h00, r); check("s2_top", {24'd0, r}, 32'hA5);
        xfer(8'h00, r); check("s2_wrap", {24'd0, r}, 32'h5A);
        cs_end();

        // JEDEC ID then 0xFF fill
        cs_begin();
        xfer(8'h9F, r);
        xfer(8'h00, r); check("s3_id0", {24'd0, r}, 32'hEF);
        xfer(8'h00, r); check("s3_id1", {24'd0, r}, 32'h40);
        xfer(8'h00, r); check("s3_id2", {24'd0, r}, 32'h16);
        xfer(8'h00, r); check("s3_fill", {24'd0, r}, 32'hFF);
        cs_end();

        // Unsupported opcode
        b0 = bad_cycles;
        cs_begin();
        xfer(8'h55, r);
        xfer(8'hFF, r); check("s4_miso0", {24'd0, r}, 32'h00);
        xfer(8'hAA, r); check("s4_miso1", {24'd0, r}, 32'h00);
        cs_end();
        check("s4_bad_pulse", bad_cycles - b0, 32'd1);

        // Aborted after 13 address bits, then clean read
        cs_begin();
        xfer(8'h03, r);
        xfer(8'h00, r);
        for (int i = 0; i < 5; i++) sbit(1'b1, rb);
        cs_end();
        cs_begin();
        read_cmd(8'h03, 24'h000010);
        xfer(8'h00, r); check("s5_byte0", {24'd0, r}, 32'h11);
        cs_end();

        // Fast read (or rejection when not built in)
        b0 = bad_cycles;
        cs_begin();
        read_cmd(8'h0B, 24'h000011);
        xfer(8'h00, r); check("s6_dummy", {24'd0, r}, 32'h00);
        xfer(8'h00, r);
`ifdef SPI_TARGET_FAST_READ_EN
        check("s6_data", {24'd0, r}, 32'h22);
        cs_end();
        check("s6_bad_pulse", bad_cycles - b0, 32'd0);
`else
        check("s6_data", {24'd0, r}, 32'h00);
        cs_end();
        check("s6_bad_pulse", bad_cycles - b0, 32'd1);
`endif

        // Reset mid-transaction: rest of it ignored until cs_n cycles
        cs_begin();
        xfer(8'h03, r);
        xfer(8'h00, r);
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(6);
        check("rst_mid_active", {31'd0, active}, 32'd0);
        xfer(8'h9F, r);
        xfer(8'h00, r); check("rst_mid_miso", {24'd0, r}, 32'h00);
        check("rst_mid_still_idle", {31'd0, active}, 32'd0);
        cs_end();
        cs_begin();
        xfer(8'h9F, r);
        xfer(8'h00, r); check("rst_after_id0", {24'd0, r}, 32'hEF);
        cs_end();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
